// File: rtl/ext_obi_sram_responder.sv
// ext_obi_sram_responder: OBI SRAM responder with grant wait states and fixed-latency responses.
// Define EXT_OBI_RESP_ERRCNT_EN to add the saturating out-of-range counter err_cnt_o.
package ext_obi_sram_responder_pkg;
    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;
    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;
endpackage

module ext_obi_sram_responder
    import ext_obi_sram_responder_pkg::*;
#(
    parameter int unsigned NUM_WORDS    = 1024,
    parameter logic [31:0] BASE_ADDR    = 32'hF000_0000,
    parameter int unsigned GNT_WAIT     = 0,
    parameter int unsigned RESP_LATENCY = 1,
    parameter logic [31:0] ERR_RDATA    = 32'hBADC_AB1E
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  obi_req_t  slave_req_i,
    output obi_resp_t slave_resp_o
`ifdef EXT_OBI_RESP_ERRCNT_EN
    ,
    output logic [15:0] err_cnt_o
`endif
);
    localparam int unsigned AW = $clog2(NUM_WORDS);
    logic [3:0] wcnt;
    logic gnt, in_range;
    logic [AW-1:0] idx;
    logic [31:0] rd_next;
    logic [31:0] mem [NUM_WORDS];
    logic [RESP_LATENCY-1:0] pv;
    logic [31:0] pd [RESP_LATENCY];
    logic unused_addr;
    assign unused_addr = ^slave_req_i.addr[1:0];
    assign gnt      = slave_req_i.req && (wcnt == 4'(GNT_WAIT));
    assign idx      = slave_req_i.addr[AW+1:2];
    assign in_range = slave_req_i.addr[31:AW+2] == BASE_ADDR[31:AW+2];
    assign rd_next  = slave_req_i.we ? 32'h0 : in_range ? mem[idx] : ERR_RDATA;
    always_ff @(posedge clk_i) begin
        wcnt <= (!rst_ni || !slave_req_i.req || gnt) ? 4'h0 : wcnt + 4'h1;
    end
    always_ff @(posedge clk_i) begin
        if (rst_ni && gnt && slave_req_i.we && in_range)
            for (int i = 0; i < 4; i++)
                if (slave_req_i.be[i]) mem[idx][8*i +: 8] <= slave_req_i.wdata[8*i +: 8];
    end
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pv <= '0;
            for (int i = 0; i < RESP_LATENCY; i++) pd[i] <= 32'h0;
        end else begin
            pv[0] <= gnt;
            pd[0] <= gnt ? rd_next : 32'h0;
            for (int i = 1; i < RESP_LATENCY; i++) begin
                pv[i] <= pv[i-1];
                pd[i] <= pd[i-1];
            end
        end
    end
    always_comb begin
        slave_resp_o        = '0;
        slave_resp_o.gnt    = gnt;
        slave_resp_o.rvalid = pv[RESP_LATENCY-1];
        slave_resp_o.rdata  = pd[RESP_LATENCY-1];
    end
`ifdef EXT_OBI_RESP_ERRCNT_EN
    always_ff @(posedge clk_i) begin
        if (!rst_ni) err_cnt_o <= 16'h0;
        else if (gnt && !in_range && err_cnt_o != 16'hFFFF) err_cnt_o <= err_cnt_o + 16'h1;
    end
`endif
endmodule

// File: tb/tb_ext_obi_sram_responder.sv
// tb_ext_obi_sram_responder: directed vectors and multi-cycle sequences across four responder configurations.
module tb_ext_obi_sram_responder;
    import ext_obi_sram_responder_pkg::*;
    localparam logic [31:0] B = 32'hF000_0000;
    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    obi_req_t  req0 = '0, req1 = '0, req2 = '0, req3 = '0;
    obi_resp_t rsp0, rsp1, rsp2, rsp3;
    int n_vec = 0;
    int n_err = 0;
`ifdef EXT_OBI_RESP_ERRCNT_EN
    logic [15:0] ec0, ec1, ec2, ec3;
`endif
    always #5 clk = ~clk;

    ext_obi_sram_responder #(.NUM_WORDS(16), .BASE_ADDR(B), .GNT_WAIT(0), .RESP_LATENCY(1)) u0 (
        .clk_i(clk), .rst_ni(rst_ni), .slave_req_i(req0), .slave_resp_o(rsp0)
`ifdef EXT_OBI_RESP_ERRCNT_EN
        , .err_cnt_o(ec0)
`endif
    );
    ext_obi_sram_responder #(.NUM_WORDS(16), .BASE_ADDR(B), .GNT_WAIT(3), .RESP_LATENCY(2)) u1 (
        .clk_i(clk), .rst_ni(rst_ni), .slave_req_i(req1), .slave_resp_o(rsp1)
`ifdef EXT_OBI_RESP_ERRCNT_EN
        , .err_cnt_o(ec1)
`endif
    );
    ext_obi_sram_responder #(.NUM_WORDS(16), .BASE_ADDR(B), .GNT_WAIT(0), .RESP_LATENCY(4)) u2 (
        .clk_i(clk), .rst_ni(rst_ni), .slave_req_i(req2), .slave_resp_o(rsp2)
`ifdef EXT_OBI_RESP_ERRCNT_EN
        , .err_cnt_o(ec2)
`endif
    );
    ext_obi_sram_responder #(.NUM_WORDS(16), .BASE_ADDR(B), .GNT_WAIT(0), .RESP_LATENCY(3)) u3 (
        .clk_i(clk), .rst_ni(rst_ni), .slave_req_i(req3), .slave_resp_o(rsp3)
`ifdef EXT_OBI_RESP_ERRCNT_EN
        , .err_cnt_o(ec3)
`endif
    );

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    function automatic obi_req_t mk(input logic we, input logic [3:0] be, input logic [31:0] addr,
                                    input logic [31:0] wdata);
        obi_req_t r;
        r.req = 1'b1;
        r.we = we;
        r.be = be;
        r.addr = addr;
        r.wdata = wdata;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    vec_t vt[16];
    obi_req_t seq[18];
    logic [31:0] exp_d[18];
    logic [31:0] t3_d[4];

    initial begin
        vt[0]  = '{1'b1, 4'hF, B + 32'h08, 32'h1234_5678, 32'h0};
        vt[1]  = '{1'b0, 4'hF, B + 32'h08, 32'h0,         32'h1234_5678};
        vt[2]  = '{1'b1, 4'hF, B + 32'h10, 32'hFFFF_FFFF, 32'h0};
        vt[3]  = '{1'b1, 4'h5, B + 32'h10, 32'hAABB_CCDD, 32'h0};
        vt[4]  = '{1'b0, 4'h0, B + 32'h10, 32'h0,         32'hFFBB_FFDD};
        vt[5]  = '{1'b1, 4'hF, B + 32'h3C, 32'h5555_AAAA, 32'h0};
        vt[6]  = '{1'b1, 4'hF, B - 32'h4,  32'hDEAD_BEEF, 32'h0};
        vt[7]  = '{1'b0, 4'hF, B + 32'h3F, 32'h0,         32'h5555_AAAA};
        vt[8]  = '{1'b0, 4'hF, B + 32'h40, 32'h0,         32'hBADC_AB1E};
        vt[9]  = '{1'b0, 4'hF, 32'h8,      32'h0,         32'hBADC_AB1E};
        vt[10] = '{1'b1, 4'hF, B + 32'h20, 32'h0,         32'h0};
        vt[11] = '{1'b1, 4'h2, B + 32'h22, 32'h0000_7700, 32'h0};
        vt[12] = '{1'b0, 4'hF, B + 32'h20, 32'h0,         32'h0000_7700};
        vt[13] = '{1'b0, 4'hF, B + 32'h08, 32'h0,         32'h1234_5678};
        vt[14] = '{1'b1, 4'hF, B + 32'h1008, 32'hFFFF_FFFF, 32'h0};
        vt[15] = '{1'b0, 4'hF, B + 32'h08, 32'h0,         32'h1234_5678};
        for (int i = 0; i < 8; i++) begin
            seq[i] = mk(1'b1, 4'hF, B + 32'(4 * i), 32'(i));
            seq[8+i] = mk(1'b0, 4'hF, B + 32'(4 * i), 32'h0);
            exp_d[i] = 32'h0;
            exp_d[8+i] = 32'(i);
        end
        seq[16] = mk(1'b1, 4'hF, B + 32'h0C, 32'hCAFE_F00D);
        seq[17] = mk(1'b0, 4'hF, B + 32'h0C, 32'h0);
        exp_d[16] = 32'h0;
        exp_d[17] = 32'hCAFE_F00D;
        t3_d = '{32'h0, 32'h0, 32'h0000_0011, 32'h0000_0022};

        repeat (3) @(negedge clk);
        #1;
        chk("rst_gnt0", 32'(rsp0.gnt), 32'h0);
        chk("rst_rvalid0", 32'(rsp0.rvalid), 32'h0);
        chk("rst_rdata0", rsp0.rdata, 32'h0);
        chk("rst_rvalid1", 32'(rsp1.rvalid), 32'h0);
        chk("rst_rvalid2", 32'(rsp2.rvalid), 32'h0);
        chk("rst_rvalid3", 32'(rsp3.rvalid), 32'h0);
`ifdef EXT_OBI_RESP_ERRCNT_EN
        chk("rst_errcnt", 32'(ec0), 32'h0);
`endif
        @(negedge clk);
        rst_ni = 1'b1;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            req0 = mk(vt[i].we, vt[i].be, vt[i].addr, vt[i].wdata);
            #1;
            chk($sformatf("v%0d_gnt", i), 32'(rsp0.gnt), 32'h1);
            chk($sformatf("v%0d_rvalid_early", i), 32'(rsp0.rvalid), 32'h0);
            @(negedge clk);
            req0 = '0;
            #1;
            chk($sformatf("v%0d_gnt_idle", i), 32'(rsp0.gnt), 32'h0);
            chk($sformatf("v%0d_rvalid", i), 32'(rsp0.rvalid), 32'h1);
            chk($sformatf("v%0d_rdata", i), rsp0.rdata, vt[i].exp);
        end
`ifdef EXT_OBI_RESP_ERRCNT_EN
        chk("errcnt", 32'(ec0), 32'd4);
`endif

        for (int j = 0; j < 5; j++) begin
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (c == 0)
                    req1 = (j < 4) ? mk(j < 2, 4'hF, B + 32'(4 * (j % 2)), (j == 0) ? 32'h11 : 32'h22) : '0;
                #1;
                if (j < 4) chk($sformatf("t3_gnt_%0d_%0d", j, c), 32'(rsp1.gnt), 32'(c == 3));
                chk($sformatf("t3_rvalid_%0d_%0d", j, c), 32'(rsp1.rvalid), 32'(j > 0 && c == 1));
                if (j > 0 && c == 1) chk($sformatf("t3_rdata_%0d", j - 1), rsp1.rdata, t3_d[j-1]);
            end
        end

        for (int t = 0; t < 22; t++) begin
            @(negedge clk);
            req2 = (t < 18) ? seq[t] : '0;
            #1;
            chk($sformatf("t5_gnt_%0d", t), 32'(rsp2.gnt), 32'(t < 18));
            chk($sformatf("t5_rvalid_%0d", t), 32'(rsp2.rvalid), 32'(t >= 4));
            if (t >= 4) chk($sformatf("t5_rdata_%0d", t - 4), rsp2.rdata, exp_d[t-4]);
        end
        @(negedge clk);
        #1;
        chk("t5_rvalid_end", 32'(rsp2.rvalid), 32'h0);

        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            req3 = (t == 0) ? mk(1'b1, 4'hF, B, 32'h0000_00A5) : (t == 1) ? mk(1'b0, 4'hF, B, 32'h0) : '0;
            if (t == 2) rst_ni = 1'b0;
            if (t == 4) rst_ni = 1'b1;
            #1;
            if (t < 2) chk($sformatf("t6_gnt_%0d", t), 32'(rsp3.gnt), 32'h1);
            if (t >= 2) begin
                chk($sformatf("t6_gnt_%0d", t), 32'(rsp3.gnt), 32'h0);
                chk($sformatf("t6_rvalid_%0d", t), 32'(rsp3.rvalid), 32'h0);
            end
        end
        chk("t6_rdata_after", rsp3.rdata, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
